pipe_buffer: RTL
================

Name: pipe_buffer

Overview:
- Parametrised inter-stage buffer for the core pipeline. It generalises the single-register hand-off between ifetch, decode, exec and writeback into a DEPTH-entry, WIDTH-bit FIFO.
- Uses the core's stall handshake on both sides and supports pipeline flush.
- Instantiated between any two stages, e.g. ifetch→decode to absorb bus latency.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- DEPTH, 2, number of entries (≥1; need not be a power of two).

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards all entries.
- in_data  input  WIDTH  payload from previous stage.
- prev_stalled  input  1  1 = in_data NOT valid this cycle.
- stall_prev  output  1  1 = buffer NOT ready to accept input.
- out_data  output  WIDTH  payload to next stage (head entry).
- stall_next  output  1  1 = out_data NOT valid.
- next_stalled  input  1  1 = next stage NOT ready to accept output.
- occupancy  output  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Push: occurs when !prev_stalled && !stall_prev && !flush. The entry is written at tail, tail advances.
- Pop: occurs when !stall_next && !next_stalled && !flush. Head advances.
- Pointers: head and tail wrap from DEPTH-1 to 0.
- Occupancy update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- stall_prev = (occupancy == DEPTH) || flush. A full buffer rejects input even if a pop occurs the same cycle; there is no full-bypass path.
- stall_next = (occupancy == 0). It never depends on next_stalled. It is registered state only (feature off).
- out_data = storage[head].
  - Held stable while !stall_next && next_stalled; the head entry is never overwritten until popped.
  - Don't-care while empty.
- Latency: a value pushed into an empty buffer is visible on out_data with stall_next=0 on the next cycle (1-cycle latency, feature off).
- Simultaneous push and pop at any 0 < occupancy < DEPTH: both performed, occupancy unchanged, FIFO order preserved.
- Flush:
  - Next cycle: head = tail = 0, occupancy = 0.
  - Any input offered in the flush cycle is dropped (stall_prev forced 1).
  - Any output handshake in the flush cycle is not counted as a pop.
  - Flush has priority over everything except rst.
- Reset (asynchronous, any time including mid-transfer):
  - head = tail = 0, occupancy = 0.
  - stall_next = 1; stall_prev = 0 once rst deasserts.
  - Storage contents are not reset.
- DEPTH = 1 degenerates to a single full/empty register; it must still pass all tests.
- No overflow or underflow is possible by construction. Assertions check that occupancy ≤ DEPTH.

Optional Feature:
- PIPE_BUFFER_BYPASS_EN
- Defined: zero-latency bypass when empty.
  - When occupancy == 0 and !flush: out_data = in_data and stall_next = prev_stalled.
  - If the next stage accepts (!next_stalled), the value passes through without being written and occupancy stays 0.
  - If next_stalled, the value is pushed normally and presented from storage next cycle.
  - stall_next is then combinational from prev_stalled but still independent of next_stalled.
- Undefined: strictly registered output, 1-cycle minimum latency as above.

Test Plan:
- Reset/fill: DEPTH=4, WIDTH=32, rst pulse; push 0xA0..0xA3 with next_stalled=1 → occupancy 1,2,3,4; stall_prev=1 after 4th push; 5th value 0xA4 held at input not accepted.
- Drain order: from full, release next_stalled → out_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; stall_next=1 and occupancy=0 after 4th pop; stall_prev falls when occupancy reaches 3.
- Streaming/wrap: continuous push and pop of 0x00..0x0F, DEPTH=3 → occupancy constant at steady state; output order exact through several pointer wraps; no data lost.
- Backpressure hold: out_data=0x55 valid, next_stalled=1 for 5 cycles while pushing 0x66,0x77 → out_data stays 0x55; after release outputs 0x55,0x66,0x77.
- Flush: occupancy=2, assert flush with prev_stalled=0 and in_data=0x99 → next cycle occupancy=0, stall_next=1; 0x99 never appears at output.
- Async reset mid-op + bypass: occupancy=3, assert rst between clock edges → stall_next=1 and occupancy=0 immediately. With PIPE_BUFFER_BYPASS_EN on an empty buffer: push 0x42 with next_stalled=0 → out_data=0x42, stall_next=0 in the same cycle, occupancy stays 0.

Source files
------------

// File: rtl/pipe_buffer.sv
// pipe_buffer: DEPTH x WIDTH FIFO between pipeline stages with stall handshake and flush.
// Define PIPE_BUFFER_BYPASS_EN for zero-latency pass-through while empty.
module pipe_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       prev_stalled,
   output logic                       stall_prev,
   output logic [WIDTH-1:0]           out_data,
   output logic                       stall_next,
   input  logic                       next_stalled,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int OW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [OW-1:0] FULL = OW'(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [OW-1:0] occ_q, occ_d;
   logic empty, push, pop, pass, wr, rd;
   always_comb begin
      empty = occ_q == '0;
      stall_prev = occ_q == FULL || flush;
`ifdef PIPE_BUFFER_BYPASS_EN
      stall_next = empty && !flush ? prev_stalled : empty;
      out_data = empty && !flush ? in_data : mem_q[head_q];
`else
      stall_next = empty;
      out_data = mem_q[head_q];
`endif
      push = !prev_stalled && !stall_prev && !flush;
      pop = !stall_next && !next_stalled && !flush;
      // a value accepted straight through while empty never touches storage
      pass = empty && push && pop;
      wr = push && !pass;
      rd = pop && !pass;
      head_d = flush ? '0 : rd ? (head_q == LAST ? '0 : head_q + PW'(1)) : head_q;
      tail_d = flush ? '0 : wr ? (tail_q == LAST ? '0 : tail_q + PW'(1)) : tail_q;
      occ_d = flush ? '0 : wr && !rd ? occ_q + OW'(1) : rd && !wr ? occ_q - OW'(1) : occ_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q <= occ_d;
      end
   always_ff @(posedge clk)
      if (wr) mem_q[tail_q] <= in_data;
   assign occupancy = occ_q;
   occ_bound: assert property (@(posedge clk) disable iff (rst) occ_q <= FULL);
endmodule
